seven_seg_scan_ctrl: RTL and testbench
======================================

Name: seven_seg_scan_ctrl

Overview:
- Multiplexed display scanner that sits directly upstream of the BCD-to-seven-segment decoder.
- Holds a multi-digit packed-BCD value and time-multiplexes it onto one shared decoder, one digit at a time.
- Each scan slot drives the decoder's 4-bit input, the common-anode/cathode digit enables and the decimal point.
- New values are double-buffered and committed only at frame boundaries, so a digit never shows a half-updated value.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- REFRESH_DIV, 50000, clock cycles each digit stays active (>=2).
- ANODE_ACTIVE_LOW, 1, 1 = an bits active-low, 0 = active-high.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- load  input  1  one-cycle strobe: capture bcd_in/dp_in into the pending buffer.
- bcd_in  input  4*NUM_DIGITS  packed BCD; digit k = bcd_in[4k+3:4k], digit 0 = least significant.
- dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit.
- blank_lz  input  1  1 = suppress leading zeros (sampled live, not buffered).
- digit_bcd  output  4  BCD code to the decoder D input; 4'hF = blank (decoder default, all segments off).
- an  output  NUM_DIGITS  digit enables; polarity set by ANODE_ACTIVE_LOW.
- dp  output  1  decimal point for the active digit.
- frame_start  output  1  one-cycle pulse when digit 0 becomes active.
- err  output  1  displayed value contains a non-BCD nibble (>9).

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset, sampled on a clk edge with rst=1, sets:
  - an all inactive (all 1 if ANODE_ACTIVE_LOW, else all 0).
  - digit_bcd=4'hF, dp=0, frame_start=0, err=0.
  - prescaler=0, idx=0.
  - disp and disp_dp cleared to 0.
  - pend_valid=0; pending contents discarded.
- rst asserted mid-frame behaves identically; a load in the same cycle as rst is ignored.
- Prescaler:
  - counts 0..REFRESH_DIV-1 and wraps.
  - tick = (prescaler==REFRESH_DIV-1).
- Digit index idx:
  - advances 0..NUM_DIGITS-1 on tick.
  - wraps to 0 when idx==NUM_DIGITS-1 and tick=1; this is the wrap event.
- Pending buffer:
  - load=1 sets pend<=bcd_in, pend_dp<=dp_in, pend_valid<=1.
  - Several loads within one frame: last wins.
- Commit, on the wrap event with pend_valid=1:
  - disp<=pend, disp_dp<=pend_dp, pend_valid<=0.
  - err<=1 if any nibble of pend is >9, else 0. err changes only on commit or reset.
- load coincident with a commit:
  - the commit uses the pend contents from before that cycle;
  - the new data goes to pend with pend_valid=1 and is committed at the next wrap.
- Leading-zero blanking:
  - digit k is blanked when blank_lz=1, k>0, and disp digits NUM_DIGITS-1..k are all 4'h0.
  - digit 0 is never blanked.
- Registered outputs, updated every cycle from the current idx/disp; latency is 1 cycle from an idx change:
  - Normal digit: digit_bcd = disp digit idx (an invalid nibble >9 is forced to 4'hF); an = only bit idx active; dp = disp_dp[idx].
  - Blanked digit: digit_bcd=4'hF, an all inactive, dp=0.
  - frame_start=1 for the single cycle in which the outputs first show idx=0 after a wrap, and also in the first cycle after reset release.
- Exactly one an bit is active at a time, or none; never more than one.
- Boundary condition: REFRESH_DIV=2 must give a slot of 2 cycles per digit with no skipped digits.

Test Plan:
(All tests use NUM_DIGITS=4, REFRESH_DIV=4, ANODE_ACTIVE_LOW=1.)
1. Reset:
   - Stimulus: hold rst=1 for 3 cycles.
   - Required: an=4'b1111, digit_bcd=4'hF, dp=0, err=0 throughout.
   - One cycle after release: an=4'b1110, digit_bcd=4'h0, frame_start=1.
   - Then an steps 1101, 1011, 0111, each held 4 cycles, repeating with a 16-cycle frame.
2. Buffered load:
   - Stimulus: load 16'h1234 with dp_in=4'b0100 mid-frame.
   - Required: outputs unchanged until the wrap.
   - Next frame: digit_bcd sequence 4, 3, 2, 1 with an 1110, 1101, 1011, 0111; dp=1 only in the slot with an=1011.
3. Blanking:
   - Stimulus: blank_lz=1, load 16'h0050.
   - Required: slots 3 and 2 give an=1111 and digit_bcd=F; slot 1 shows 5; slot 0 shows 0.
   - Stimulus: load 16'h0000.
   - Required: only slot 0 is active, showing 0.
   - Stimulus: blank_lz=0.
   - Required: all four slots show 0.
4. Invalid BCD:
   - Stimulus: load 16'h12A4.
   - Required: after the commit, err=1; slot 1 gives digit_bcd=F with an=1101; the other slots show 4, 2, 1.
   - Stimulus: load 16'h5678.
   - Required: err=0 at the next commit.
5. Load collisions:
   - Stimulus: load 16'h1111 then 16'h2222 in the same frame.
   - Required: only 2222 is displayed.
   - Stimulus: load 16'h3333 exactly on the wrap cycle while 16'h2222 is pending.
   - Required: the next frame shows 2222 and the frame after shows 3333.
6. Mid-frame reset:
   - Stimulus: while 16'h9876 is displayed and 16'h1111 is pending, pulse rst=1 for 1 cycle during slot 2.
   - Required: the reset values from test 1 appear on the next edge.
   - After release: the display shows 0000, not 1111, and err=0.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed packed-BCD display scanner feeding one shared 7-seg decoder.
// Loads are double-buffered and committed only at frame boundaries.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 50000,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [3:0]              digit_bcd,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    dp,
    output logic                    frame_start,
    output logic                    err
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF =
        (ANODE_ACTIVE_LOW != 0) ? '1 : '0;

    logic [PW-1:0]           prescaler;
    logic [IW-1:0]           idx;
    logic [IW-1:0]           out_idx;
    logic                    fresh;
    logic [4*NUM_DIGITS-1:0] disp;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [4*NUM_DIGITS-1:0] pend;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    pend_valid;

    logic                    tick;
    logic                    wrap;
    logic                    pend_bad;
    logic [3:0]              cur;
    logic                    cur_dp;
    logic                    cur_lz;
    logic                    lz_run;
    logic [NUM_DIGITS-1:0]   onehot;
    logic [NUM_DIGITS-1:0]   an_on;
    logic                    blanked;

    assign tick = (prescaler == P_LAST);
    assign wrap = tick && (idx == I_LAST);

    always_comb begin
        pend_bad = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (pend[4*k +: 4] > 4'd9) pend_bad = 1'b1;
        end
    end

    // Walk from the most significant digit so lz_run says "this digit and
    // everything above it is zero" at the point the active digit is found.
    always_comb begin
        cur    = 4'h0;
        cur_dp = 1'b0;
        cur_lz = 1'b0;
        lz_run = 1'b1;
        onehot = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            lz_run = lz_run && (disp[4*k +: 4] == 4'h0);
            if (idx == IW'(k)) begin
                cur       = disp[4*k +: 4];
                cur_dp    = disp_dp[k];
                cur_lz    = lz_run;
                onehot[k] = 1'b1;
            end
        end
    end

    assign an_on   = (ANODE_ACTIVE_LOW != 0) ? ~onehot : onehot;
    assign blanked = blank_lz && (idx != '0) && cur_lz;

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler   <= '0;
            idx         <= '0;
            out_idx     <= '0;
            fresh       <= 1'b1;
            disp        <= '0;
            disp_dp     <= '0;
            pend        <= '0;
            pend_dp     <= '0;
            pend_valid  <= 1'b0;
            err         <= 1'b0;
            digit_bcd   <= 4'hF;
            an          <= AN_OFF;
            dp          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            prescaler <= tick ? '0 : prescaler + PW'(1);
            if (tick) idx <= wrap ? '0 : idx + IW'(1);

            if (wrap && pend_valid) begin
                disp       <= pend;
                disp_dp    <= pend_dp;
                err        <= pend_bad;
                pend_valid <= 1'b0;
            end
            // A load on the commit cycle refills pend after the old
            // contents have been taken.
            if (load) begin
                pend       <= bcd_in;
                pend_dp    <= dp_in;
                pend_valid <= 1'b1;
            end

            if (blanked) begin
                digit_bcd <= 4'hF;
                an        <= AN_OFF;
                dp        <= 1'b0;
            end else begin
                digit_bcd <= (cur > 4'd9) ? 4'hF : cur;
                an        <= an_on;
                dp        <= cur_dp;
            end

            frame_start <= (idx == '0) && (fresh || (out_idx != '0));
            out_idx     <= idx;
            fresh       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: directed slot tables, corner sequences
// and random traffic against a frame-arithmetic reference model.
module tb_seven_seg_scan_ctrl;

    localparam int N = 4;
    localparam int R = 4;
    localparam int F = N * R;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  digit_bcd;
    logic [3:0]  an;
    logic        dp;
    logic        frame_start;
    logic        err;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS(N),
        .REFRESH_DIV(R),
        .ANODE_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .bcd_in(bcd_in),
        .dp_in(dp_in),
        .blank_lz(blank_lz),
        .digit_bcd(digit_bcd),
        .an(an),
        .dp(dp),
        .frame_start(frame_start),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: n counts non-reset edges since the last reset.
    int          n;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_dp, m_pdp;
    logic        m_pv, m_err;
    logic [3:0]  e_bcd, e_an;
    logic        e_dp, e_fs;

    function automatic logic any_bad(logic [15:0] v);
        for (int k = 0; k < N; k++)
            if (((v >> (4 * k)) & 16'hF) > 16'd9) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge();
        int         slot;
        logic [3:0] nib;
        logic       blk;
        if (rst) begin
            n = 0; m_disp = 0; m_dp = 0; m_pend = 0; m_pdp = 0;
            m_pv = 0; m_err = 0;
            e_bcd = 4'hF; e_an = 4'hF; e_dp = 0; e_fs = 0;
            return;
        end
        slot  = (n / R) % N;
        nib   = 4'((m_disp >> (4 * slot)) & 16'hF);
        blk   = blank_lz && slot > 0 && ((m_disp >> (4 * slot)) == 16'h0);
        e_bcd = blk ? 4'hF : (nib > 4'd9 ? 4'hF : nib);
        e_an  = blk ? 4'hF : ~(4'b0001 << slot);
        e_dp  = blk ? 1'b0 : m_dp[slot];
        e_fs  = (n % F == 0);
        if (n % F == F - 1 && m_pv) begin
            m_disp = m_pend; m_dp = m_pdp;
            m_err = any_bad(m_pend); m_pv = 0;
        end
        if (load) begin
            m_pend = bcd_in; m_pdp = dp_in; m_pv = 1;
        end
        n++;
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp,
                     $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk($sformatf("model n=%0d", n),
            {21'd0, digit_bcd, an, dp, frame_start, err},
            {21'd0, e_bcd, e_an, e_dp, e_fs, m_err});
    endtask

    task automatic align(int p);
        for (int i = 0; i < 2 * F && (n % F) != p; i++) step();
        chk("align", 32'(n % F), 32'(p));
    endtask

    task automatic do_load(logic [15:0] v, logic [3:0] d);
        bcd_in = v; dp_in = d; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    typedef struct packed {
        logic        blank;
        logic [15:0] bcd;
        logic [3:0]  dpi;
        logic [15:0] e_bcd;
        logic [15:0] e_an;
        logic [3:0]  e_dp;
        logic        e_err;
    } vec_t;

    vec_t vt[6];

    initial begin
        // e_bcd/e_an hold slot s in bits [4s+3:4s]; e_dp bit s is slot s.
        vt[0] = '{1'b0, 16'h1234, 4'b0100, 16'h1234, 16'h7BDE, 4'b0100, 1'b0};
        vt[1] = '{1'b1, 16'h0050, 4'b1111, 16'hFF50, 16'hFFDE, 4'b0011, 1'b0};
        vt[2] = '{1'b1, 16'h0000, 4'b0000, 16'hFFF0, 16'hFFFE, 4'b0000, 1'b0};
        vt[3] = '{1'b0, 16'h0000, 4'b0000, 16'h0000, 16'h7BDE, 4'b0000, 1'b0};
        vt[4] = '{1'b0, 16'h12A4, 4'b0000, 16'h12F4, 16'h7BDE, 4'b0000, 1'b1};
        vt[5] = '{1'b0, 16'h5678, 4'b0000, 16'h5678, 16'h7BDE, 4'b0000, 1'b0};

        rst = 1'b1; load = 1'b0; bcd_in = '0; dp_in = '0; blank_lz = 1'b0;
        n = 0; m_disp = 0; m_dp = 0; m_pend = 0; m_pdp = 0;
        m_pv = 0; m_err = 0;

        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_an", 32'(an), 32'hF);
            chk("rst_bcd", 32'(digit_bcd), 32'hF);
            chk("rst_dp_err", {30'd0, dp, err}, 32'd0);
        end
        rst = 1'b0;
        step();
        chk("rel_an", 32'(an), 32'hE);
        chk("rel_bcd", 32'(digit_bcd), 32'h0);
        chk("rel_fs", 32'(frame_start), 32'd1);
        for (int c = 1; c < 2 * F; c++) begin
            logic [3:0] ea;
            step();
            ea = ~(4'b0001 << ((c / R) % N));
            chk($sformatf("scan_an c=%0d", c), 32'(an), 32'(ea));
            chk($sformatf("scan_fs c=%0d", c), 32'(frame_start),
                32'(c % F == 0));
        end

        foreach (vt[i]) begin
            blank_lz = vt[i].blank;
            align(6);
            do_load(vt[i].bcd, vt[i].dpi);
            for (int s = 0; s < N; s++) begin
                align(4 * s);
                step();
                chk($sformatf("vec%0d_bcd s%0d", i, s), 32'(digit_bcd),
                    32'(vt[i].e_bcd[4*s +: 4]));
                chk($sformatf("vec%0d_an s%0d", i, s), 32'(an),
                    32'(vt[i].e_an[4*s +: 4]));
                chk($sformatf("vec%0d_dp s%0d", i, s), 32'(dp),
                    32'(vt[i].e_dp[s]));
                chk($sformatf("vec%0d_err s%0d", i, s), 32'(err),
                    32'(vt[i].e_err));
                chk($sformatf("vec%0d_fs s%0d", i, s), 32'(frame_start),
                    32'(s == 0));
            end
        end

        blank_lz = 1'b0;
        align(3);
        do_load(16'h1111, 4'h0);
        align(8);
        do_load(16'h2222, 4'h0);
        align(F - 1);
        do_load(16'h3333, 4'h0);
        for (int s = 0; s < N; s++) begin
            align(4 * s);
            step();
            chk($sformatf("coll_2222 s%0d", s), 32'(digit_bcd), 32'h2);
        end
        for (int s = 0; s < N; s++) begin
            align(4 * s);
            step();
            chk($sformatf("coll_3333 s%0d", s), 32'(digit_bcd), 32'h3);
        end

        align(6);
        do_load(16'h9876, 4'h0);
        align(2);
        chk("mid_disp9876", 32'(digit_bcd), 32'h6);
        do_load(16'h1111, 4'h0);
        align(9);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_an", 32'(an), 32'hF);
        chk("mid_rst_bcd", 32'(digit_bcd), 32'hF);
        chk("mid_rst_dp_fs_err", {29'd0, dp, frame_start, err}, 32'd0);
        step();
        chk("mid_rel_an", 32'(an), 32'hE);
        chk("mid_rel_fs", 32'(frame_start), 32'd1);
        for (int c = 0; c < 2 * F + 4; c++) begin
            step();
            chk($sformatf("mid_zero c=%0d", c), {27'd0, digit_bcd, err},
                32'd0);
        end

        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(0, 199) == 0);
            load = ($urandom_range(0, 5) == 0);
            bcd_in = 16'($urandom);
            case ($urandom_range(0, 3))
                0: bcd_in = bcd_in & 16'h000F;
                1: bcd_in = bcd_in & 16'h00FF;
                default: ;
            endcase
            dp_in = 4'($urandom);
            if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
            step();
        end
        rst = 1'b0; load = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
